data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/cache_pkg.sv | 21 ++
 rtl/data_cache_if.sv | 30 +++
 rtl/cache_array.sv | 42 ++++
 rtl/data_cache.sv | 148 ++++++++++++++
 tb/tb_data_cache.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int DEF_LINES       = 32;
    localparam int DEF_MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_THROUGH
    } state_t;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return 32 - $clog2(lines);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache.
interface data_cache_if;

    logic [31:0] address;
    logic [31:0] writeData;
    logic        cpuRead;
    logic        cpuWrite;
    logic [31:0] readData;
    logic        stall;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;
    logic [15:0] hitCount;
    logic [15:0] missCount;

    modport slave (
        input  address, writeData, cpuRead, cpuWrite, memReadData,
        output readData, stall, memAddress, memWriteData,
        output memRead, memWrite, hitCount, missCount
    );

    modport master (
        output address, writeData, cpuRead, cpuWrite, memReadData,
        input  readData, stall, memAddress, memWriteData,
        input  memRead, memWrite, hitCount, missCount
    );

endinterface

// File: rtl/cache_array.sv
// Valid/tag/data storage: one combinational read port, one write port.
module cache_array #(
    parameter int LINES   = 32,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 27
) (
    input  logic               i_clk,
    input  logic               i_clear,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [31:0]        o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [31:0]        i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge i_clk) begin
        if (i_clear)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_wr_index] <= 1'b1;
    end

    // Clear wins so an abandoned refill never lands in the array.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_clear) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through data cache, no write-allocate.
module data_cache
    import cache_pkg::*;
#(
    parameter int LINES       = DEF_LINES,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input logic         clk,
    input logic         rst,
    data_cache_if.slave bus
);

    localparam int         INDEX_W = index_w(LINES);
    localparam int         TAG_W   = tag_w(LINES);
    localparam logic [3:0] LAST    = 4'(MEM_LATENCY - 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_count;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [15:0]        r_hits;
    logic [15:0]        r_misses;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [31:0]        w_line_data;
    logic               w_hit;
    logic               w_last;
    logic               w_we;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0]   w_wr_tag;
    logic [31:0]        w_wr_data;
    logic               w_hit_inc;
    logic               w_miss_inc;

    assign w_idx  = bus.address[INDEX_W-1:0];
    assign w_tag  = bus.address[31:INDEX_W];
    assign w_hit  = w_valid && (w_line_tag == w_tag);
    assign w_last = (r_count == LAST);

    cache_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .i_clk      (clk),
        .i_clear    (rst),
        .i_rd_index (w_idx),
        .o_rd_valid (w_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_we),
        .i_wr_index (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    always_comb begin
        w_next           = r_state;
        bus.stall        = 1'b0;
        bus.readData     = '0;
        bus.memAddress   = '0;
        bus.memWriteData = '0;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        w_we             = 1'b0;
        w_wr_idx         = w_idx;
        w_wr_tag         = w_tag;
        w_wr_data        = bus.writeData;
        w_hit_inc        = 1'b0;
        w_miss_inc       = 1'b0;
        // Outputs stay quiet for the whole reset cycle, whatever the state.
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.cpuWrite) begin
                        bus.stall = 1'b1;
                        w_we      = w_hit;
                        w_next    = WRITE_THROUGH;
                    end else if (bus.cpuRead) begin
                        if (w_hit) begin
                            bus.readData = w_line_data;
                            w_hit_inc    = 1'b1;
                        end else begin
                            bus.stall  = 1'b1;
                            w_miss_inc = 1'b1;
                            w_next     = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    bus.memRead    = 1'b1;
                    bus.memAddress = r_addr;
                    bus.stall      = !w_last;
                    if (w_last) begin
                        bus.readData = bus.memReadData;
                        w_we         = 1'b1;
                        w_wr_idx     = r_addr[INDEX_W-1:0];
                        w_wr_tag     = r_addr[31:INDEX_W];
                        w_wr_data    = bus.memReadData;
                        w_next       = IDLE;
                    end
                end
                WRITE_THROUGH: begin
                    bus.memWrite     = 1'b1;
                    bus.memAddress   = r_addr;
                    bus.memWriteData = r_wdata;
                    bus.stall        = !w_last;
                    if (w_last)
                        w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE || w_last)
                r_count <= '0;
            else
                r_count <= r_count + 4'd1;
            if (r_state == IDLE && (bus.cpuRead || bus.cpuWrite))
                r_addr <= bus.address;
            if (r_state == IDLE && bus.cpuWrite)
                r_wdata <= bus.writeData;
            if (w_hit_inc && r_hits != 16'hFFFF)
                r_hits <= r_hits + 16'd1;
            if (w_miss_inc && r_misses != 16'hFFFF)
                r_misses <= r_misses + 16'd1;
        end
    end

    assign bus.hitCount  = r_hits;
    assign bus.missCount = r_misses;

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a line-level reference model.
module tb_data_cache;
    import cache_pkg::*;

    localparam int LINES = 32;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_cache_if bus();

    data_cache #(
        .LINES       (LINES),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bmem [logic [31:0]];
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    logic [31:0] mdata  [LINES];
    int          mhits;
    int          mmisses;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (bmem.exists(a))
            return bmem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++)
            mvalid[i] = 1'b0;
        mhits   = 0;
        mmisses = 0;
    endtask

    task automatic op(input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
        int          idx;
        logic [31:0] tg;
        bit          hit;
        int          exp_cyc;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_data;
        int          cyc;
        int          nrd;
        int          nwr;
        bit          bus_ok;
        bit          both;
        bit          done;
        bit          tmo;
        logic [31:0] got;
        idx      = int'(a % LINES);
        tg       = a / LINES;
        hit      = mvalid[idx] && (mtag[idx] == tg);
        exp_rd   = 0;
        exp_wr   = 0;
        exp_data = '0;
        if (wr) begin
            exp_cyc = LAT + 1;
            exp_wr  = LAT;
            if (hit)
                mdata[idx] = d;
        end else if (hit) begin
            exp_cyc  = 1;
            exp_data = mdata[idx];
            mhits    = sat(mhits);
        end else begin
            exp_cyc     = LAT + 1;
            exp_rd      = LAT;
            exp_data    = mem_value(a);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            mdata[idx]  = exp_data;
            mmisses     = sat(mmisses);
        end
        cyc    = 0;
        nrd    = 0;
        nwr    = 0;
        bus_ok = 1'b1;
        both   = 1'b0;
        done   = 1'b0;
        tmo    = 1'b0;
        got    = '0;
        @(negedge clk);
        bus.cpuRead   = rd;
        bus.cpuWrite  = wr;
        bus.address   = a;
        bus.writeData = d;
        while (!done) begin
            #1;
            bus.memReadData = mem_value(bus.memAddress);
            #1;
            cyc++;
            if (bus.memRead)
                nrd++;
            if (bus.memWrite)
                nwr++;
            if (bus.memRead && bus.memWrite)
                both = 1'b1;
            if ((bus.memRead || bus.memWrite) && bus.memAddress !== a)
                bus_ok = 1'b0;
            if (bus.memWrite && bus.memWriteData !== d)
                bus_ok = 1'b0;
            if (!bus.stall) begin
                done = 1'b1;
                got  = bus.readData;
            end else if (cyc >= 40) begin
                done = 1'b1;
                tmo  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        if (wr)
            bmem[a] = d;
        check("timeout", 32'(tmo), 32'd0);
        check("cycles", cyc, exp_cyc);
        check("memRead_cycles", nrd, exp_rd);
        check("memWrite_cycles", nwr, exp_wr);
        check("mem_bus", 32'(bus_ok), 32'd1);
        check("rd_wr_overlap", 32'(both), 32'd0);
        if (!wr)
            check("readData", got, exp_data);
        check("hitCount", 32'(bus.hitCount), mhits);
        check("missCount", 32'(bus.missCount), mmisses);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        bus.cpuRead  = 1'b0;
        bus.cpuWrite = 1'b0;
        #1;
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_memRead"}, 32'(bus.memRead), 32'd0);
        check({tag, "_memWrite"}, 32'(bus.memWrite), 32'd0);
        check({tag, "_readData"}, bus.readData, 32'd0);
        check({tag, "_memAddress"}, bus.memAddress, 32'd0);
    endtask

    initial begin
        int          n;
        int          kind;
        logic [31:0] a;
        rst              = 1'b1;
        bus.cpuRead      = 1'b0;
        bus.cpuWrite     = 1'b0;
        bus.address      = '0;
        bus.writeData    = '0;
        bus.memReadData  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        idle_check("in_reset");
        check("rst_hitCount", 32'(bus.hitCount), 32'd0);
        check("rst_missCount", 32'(bus.missCount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("after_reset");

        bmem[32'h10] = 32'hDEADBEEF;
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b0, 1'b1, 32'h10, 32'h12345678);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b1, 1'b0, 32'h30, 32'h0);
        op(1'b1, 1'b1, 32'h30, 32'h0BADF00D);
        op(1'b1, 1'b0, 32'h30, 32'h0);

        // Reset lands in the second refill cycle of a miss on 0x50.
        @(negedge clk);
        bus.cpuRead  = 1'b1;
        bus.cpuWrite = 1'b0;
        bus.address  = 32'h50;
        #1;
        check("mid_stall_idle", 32'(bus.stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_memRead_pre", 32'(bus.memRead), 32'd1);
        rst         = 1'b1;
        bus.cpuRead = 1'b0;
        #1;
        check("mid_memRead_rst", 32'(bus.memRead), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_check("mid_after");
        check("mid_hitCount", 32'(bus.hitCount), 32'd0);
        check("mid_missCount", 32'(bus.missCount), 32'd0);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b1, 1'b0, 32'h50, 32'h0);

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 7));
            a    = 32'($urandom_range(0, 4 * LINES - 1));
            if (kind <= 3)
                op(1'b1, 1'b0, a, 32'h0);
            else if (kind <= 5)
                op(1'b0, 1'b1, a, $urandom);
            else if (kind == 6)
                op(1'b1, 1'b1, a, $urandom);
            else
                idle_check("rand_idle");
        end

        op(1'b1, 1'b0, 32'h10, 32'h0);
        n = 65534 - mhits;
        @(negedge clk);
        bus.cpuRead  = 1'b1;
        bus.cpuWrite = 1'b0;
        bus.address  = 32'h10;
        repeat (n) @(posedge clk);
        #1;
        bus.cpuRead = 1'b0;
        mhits       = 65534;
        @(negedge clk);
        check("sat_fffe", 32'(bus.hitCount), 32'h0000FFFE);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        op(1'b1, 1'b0, 32'h10, 32'h0);
        check("sat_hold", 32'(bus.hitCount), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
